uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller for the UART receiver. It owns the receiver's parity configuration, applying software changes only while the serial line is quiet, so a frame is never decoded with mixed settings. It also captures every received byte into a small show-ahead FIFO and presents it downstream on a valid/ready handshake, with a sticky overrun flag. It sits between the UART receiver top and the consuming logic.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- IDLE_CYCLES, 16: number of consecutive high-line cycles before the line counts as quiet; at least 1.
- CLK  in  1  the single clock.
- RST  in  1  asynchronous, active-high reset.
- RxIn  in  1  serial line, the same net as the receiver input; it is already synchronous to CLK.
- CfgWrite  in  1  one-cycle request to load a new configuration.
- CfgParityEn  in  1  requested parity enable; sampled when CfgWrite is high.
- CfgParityType  in  1  requested parity type; sampled when CfgWrite is high.
- ParityEn  out  1  applied parity enable, driven to the receiver.
- ParityType  out  1  applied parity type, driven to the receiver.
- CfgPending  out  1  high while a requested configuration is waiting to be applied.
- PData  in  8  receiver parallel data.
- DataValid  in  1  receiver frame-valid strobe.
- OutData  out  8  head FIFO entry; only meaningful while OutValid is high.
- OutValid  out  1  FIFO not empty.
- OutReady  in  1  downstream accept.
- Level  out  clog2(DEPTH)+1  current FIFO occupancy.
- Overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- ClearOverrun  in  1  clears Overrun.

## Operation
- Reset values: ParityEn=0, ParityType=0, CfgPending=0, OutValid=0, OutData=0, Level=0, Overrun=0. The quiet counter and the DataValid edge register also reset to 0.
- Quiet counter:
  - Increments each cycle RxIn=1, saturating at IDLE_CYCLES.
  - Clears to 0 in any cycle RxIn=0.
  - The line is "quiet" when the counter equals IDLE_CYCLES.
- Config FSM has three states: IDLE, WAIT_QUIET, APPLY.
  - IDLE: on CfgWrite, latch the requested values into shadow registers and go to WAIT_QUIET.
  - WAIT_QUIET: a new CfgWrite overwrites the shadow registers and the FSM stays in WAIT_QUIET. Go to APPLY when the line is quiet and there is no DataValid rising edge in that cycle.
  - APPLY: copy the shadow registers to ParityEn/ParityType and return to IDLE. A CfgWrite arriving in APPLY re-latches the shadow registers and sends the FSM to WAIT_QUIET, not IDLE.
  - CfgPending is high in WAIT_QUIET and APPLY.
- Byte capture:
  - One write per DataValid rising edge. The edge is detected against a registered copy of DataValid; a level held high writes only once.
  - The written data is PData in the edge cycle.
- FIFO:
  - OutData always shows the head entry.
  - A pop happens when OutValid and OutReady are both high.
  - Push and pop in the same cycle leave Level unchanged. This also applies when full: the push is accepted and Overrun is not set.
  - Push when full with no pop: the byte is dropped and Overrun is set.
  - Pointers wrap modulo DEPTH; Level ranges 0..DEPTH.
- Overrun stays set until ClearOverrun. If a set and a clear occur in the same cycle, the set wins.
- A mid-operation RST clears the FIFO contents, pending config and flags immediately (asynchronously).

## Timing
- DataValid rising edge in cycle n: Level increments in n+1. If the FIFO was empty, OutValid rises and OutData is valid in n+1.
- Pop in cycle n: the next entry appears on OutData in n+1, or OutValid falls in n+1 if the FIFO is now empty.
- CfgWrite in cycle n on an already-quiet line: CfgPending=1 in n+1, the FSM reaches APPLY in n+2, ParityEn/ParityType take the new values in n+3, and CfgPending=0 in n+3.
- A RxIn low pulse while in WAIT_QUIET restarts the quiet window. The apply then needs IDLE_CYCLES further high cycles.
- All outputs are registered except OutValid, CfgPending and Level, which decode directly from registers.

## Test plan
- Reset and idle: assert RST mid-run with 3 bytes queued -> immediately Level=0, OutValid=0, Overrun=0, ParityEn=0, CfgPending=0.
- Quiet-gated config: hold RxIn=0, pulse CfgWrite with En=1, Type=1. Release RxIn high at cycle t -> ParityEn=1 and ParityType=1 exactly at t+IDLE_CYCLES+2, and CfgPending low in that same cycle.
- Config overwrite: CfgWrite (1,0) then CfgWrite (0,1) while pending -> only (0,1) is ever applied; ParityEn never goes to 1.
- FIFO order: push 0xA5, 0x3C, 0xFF with OutReady=0 -> Level=3; then hold OutReady=1 -> OutData is 0xA5, 0x3C, 0xFF on consecutive cycles, then OutValid=0.
- Overrun: with DEPTH=4, push 5 bytes with no reads -> Level=4, Overrun=1, 5th byte absent. Pulse ClearOverrun -> Overrun=0. Push while full with OutReady=1 -> no overrun.
- Edge detection: hold DataValid high for 10 cycles with PData=0x55 -> exactly one entry written, Level=1.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: quiet-gated parity configuration plus a show-ahead
// byte FIFO with valid/ready output and a sticky overrun flag.
module uart_rx_ctrl #(
   parameter int DEPTH       = 4,
   parameter int IDLE_CYCLES = 16
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       RxIn,
   input  logic                       CfgWrite,
   input  logic                       CfgParityEn,
   input  logic                       CfgParityType,
   output logic                       ParityEn,
   output logic                       ParityType,
   output logic                       CfgPending,
   input  logic [7:0]                 PData,
   input  logic                       DataValid,
   output logic [7:0]                 OutData,
   output logic                       OutValid,
   input  logic                       OutReady,
   output logic [$clog2(DEPTH):0]     Level,
   output logic                       Overrun,
   input  logic                       ClearOverrun
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(IDLE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_QUIET = 2'd1,
      APPLY      = 2'd2
   } cfg_state_e;

   cfg_state_e        state_q, state_d;
   logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
   logic              dv_q;
   logic              shadow_en_q, shadow_en_d;
   logic              shadow_type_q, shadow_type_d;
   logic              par_en_q, par_en_d;
   logic              par_type_q, par_type_d;

   logic [7:0]        mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q, rd_next;
   logic [LW-1:0]     count_q, count_d;
   logic [7:0]        out_data_q, out_data_d;
   logic              overrun_q, overrun_d;

   logic              quiet, dv_rise, push, pop, full, wr_en, ovf_set;

   assign quiet   = (idle_cnt_q == CW'(IDLE_CYCLES));
   assign dv_rise = DataValid & ~dv_q;
   assign full    = (count_q == LW'(DEPTH));
   assign push    = dv_rise;
   assign pop     = OutValid & OutReady;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign wr_en   = push & (~full | pop);
   assign ovf_set = push & full & ~pop;
   assign rd_next = rd_ptr_q + PW'(1);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (!RxIn) begin
         idle_cnt_d = '0;
      end else if (!quiet) begin
         idle_cnt_d = idle_cnt_q + CW'(1);
      end
   end

   always_comb begin
      state_d       = state_q;
      shadow_en_d   = shadow_en_q;
      shadow_type_d = shadow_type_q;
      par_en_d      = par_en_q;
      par_type_d    = par_type_q;
      if (CfgWrite) begin
         shadow_en_d   = CfgParityEn;
         shadow_type_d = CfgParityType;
      end
      unique case (state_q)
         IDLE: begin
            if (CfgWrite) state_d = WAIT_QUIET;
         end
         WAIT_QUIET: begin
            if (!CfgWrite && quiet && !dv_rise) state_d = APPLY;
         end
         APPLY: begin
            par_en_d   = shadow_en_q;
            par_type_d = shadow_type_q;
            state_d    = CfgWrite ? WAIT_QUIET : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + LW'(1);
         2'b01:   count_d = count_q - LW'(1);
         default: count_d = count_q;
      endcase

      // The head register tracks what mem_q[rd_ptr_q] will hold next cycle.
      out_data_d = out_data_q;
      if (pop) begin
         if (count_q == LW'(1)) begin
            if (push) out_data_d = PData;
         end else begin
            out_data_d = mem_q[rd_next];
         end
      end else if (count_q == '0 && push) begin
         out_data_d = PData;
      end

      overrun_d = overrun_q;
      if (ovf_set)           overrun_d = 1'b1;
      else if (ClearOverrun) overrun_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= IDLE;
         idle_cnt_q    <= '0;
         dv_q          <= 1'b0;
         shadow_en_q   <= 1'b0;
         shadow_type_q <= 1'b0;
         par_en_q      <= 1'b0;
         par_type_q    <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         out_data_q    <= '0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         idle_cnt_q    <= idle_cnt_d;
         dv_q          <= DataValid;
         shadow_en_q   <= shadow_en_d;
         shadow_type_q <= shadow_type_d;
         par_en_q      <= par_en_d;
         par_type_q    <= par_type_d;
         count_q       <= count_d;
         out_data_q    <= out_data_d;
         overrun_q     <= overrun_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)   rd_ptr_q <= rd_next;
      end
   end

   // NOTE: storage is not reset; the count and pointers decide which entries are valid.
   always_ff @(posedge CLK) begin
      if (wr_en) mem_q[wr_ptr_q] <= PData;
   end

   assign ParityEn   = par_en_q;
   assign ParityType = par_type_q;
   assign CfgPending = (state_q == WAIT_QUIET) || (state_q == APPLY);
   assign OutData    = out_data_q;
   assign OutValid   = (count_q != '0);
   assign Level      = count_q;
   assign Overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=4, IDLE_CYCLES=16).
module tb_uart_rx_ctrl;

   localparam int DEPTH       = 4;
   localparam int IDLE_CYCLES = 16;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RxIn;
   logic       CfgWrite, CfgParityEn, CfgParityType;
   logic       ParityEn, ParityType, CfgPending;
   logic [7:0] PData;
   logic       DataValid;
   logic [7:0] OutData;
   logic       OutValid, OutReady;
   logic [2:0] Level;
   logic       Overrun, ClearOverrun;

   int n_cmp = 0;
   int n_err = 0;

   uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_CYCLES(IDLE_CYCLES)) dut (
      .CLK(CLK), .RST(RST), .RxIn(RxIn),
      .CfgWrite(CfgWrite), .CfgParityEn(CfgParityEn), .CfgParityType(CfgParityType),
      .ParityEn(ParityEn), .ParityType(ParityType), .CfgPending(CfgPending),
      .PData(PData), .DataValid(DataValid),
      .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
      .Level(Level), .Overrun(Overrun), .ClearOverrun(ClearOverrun)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      PData = b;
      DataValid = 1'b1;
      tick();
      DataValid = 1'b0;
      tick();
   endtask

   task automatic cfg_write(input logic en, input logic typ);
      CfgWrite = 1'b1;
      CfgParityEn = en;
      CfgParityType = typ;
      tick();
      CfgWrite = 1'b0;
   endtask

   initial begin
      RST = 1'b1; RxIn = 1'b1; CfgWrite = 1'b0; CfgParityEn = 1'b0; CfgParityType = 1'b0;
      PData = 8'h00; DataValid = 1'b0; OutReady = 1'b0; ClearOverrun = 1'b0;
      tick(3);
      RST = 1'b0;
      tick();

      // Reset state
      check("rst_level", 32'(Level), 0);
      check("rst_valid", 32'(OutValid), 0);
      check("rst_data", 32'(OutData), 0);
      check("rst_overrun", 32'(Overrun), 0);
      check("rst_par_en", 32'(ParityEn), 0);
      check("rst_par_type", 32'(ParityType), 0);
      check("rst_pending", 32'(CfgPending), 0);

      // FIFO order with first-push latency
      PData = 8'hA5; DataValid = 1'b1;
      tick();
      DataValid = 1'b0;
      check("first_level", 32'(Level), 1);
      check("first_valid", 32'(OutValid), 1);
      check("first_data", 32'(OutData), 32'hA5);
      tick();
      push_byte(8'h3C);
      push_byte(8'hFF);
      check("order_level3", 32'(Level), 3);
      OutReady = 1'b1;
      check("order_d0", 32'(OutData), 32'hA5);
      tick();
      check("order_d1", 32'(OutData), 32'h3C);
      tick();
      check("order_d2", 32'(OutData), 32'hFF);
      check("order_valid2", 32'(OutValid), 1);
      tick();
      check("order_empty", 32'(OutValid), 0);
      check("order_level0", 32'(Level), 0);
      OutReady = 1'b0;

      // Overrun: fifth byte dropped
      push_byte(8'h01);
      push_byte(8'h02);
      push_byte(8'h03);
      push_byte(8'h04);
      check("ovr_full_level", 32'(Level), 4);
      check("ovr_not_yet", 32'(Overrun), 0);
      push_byte(8'h05);
      check("ovr_level", 32'(Level), 4);
      check("ovr_set", 32'(Overrun), 1);
      ClearOverrun = 1'b1;
      tick();
      ClearOverrun = 1'b0;
      check("ovr_clear", 32'(Overrun), 0);

      // Push while full with a simultaneous pop: accepted, no overrun
      PData = 8'h66; DataValid = 1'b1; OutReady = 1'b1;
      tick();
      DataValid = 1'b0; OutReady = 1'b0;
      check("full_pp_level", 32'(Level), 4);
      check("full_pp_ovr", 32'(Overrun), 0);
      check("full_pp_head", 32'(OutData), 32'h02);
      tick();

      // Set and clear in the same cycle: set wins
      PData = 8'h77; DataValid = 1'b1; ClearOverrun = 1'b1;
      tick();
      DataValid = 1'b0; ClearOverrun = 1'b0;
      check("set_wins", 32'(Overrun), 1);
      ClearOverrun = 1'b1;
      tick();
      ClearOverrun = 1'b0;
      check("clear_after", 32'(Overrun), 0);

      OutReady = 1'b1;
      check("drain0", 32'(OutData), 32'h02);
      tick();
      check("drain1", 32'(OutData), 32'h03);
      tick();
      check("drain2", 32'(OutData), 32'h04);
      tick();
      check("drain3", 32'(OutData), 32'h66);
      tick();
      check("drain_empty", 32'(OutValid), 0);
      OutReady = 1'b0;

      // Edge detection: a held level writes once
      PData = 8'h55; DataValid = 1'b1;
      tick(10);
      DataValid = 1'b0;
      tick();
      check("edge_level", 32'(Level), 1);
      check("edge_data", 32'(OutData), 32'h55);
      OutReady = 1'b1;
      tick();
      OutReady = 1'b0;
      check("edge_drained", 32'(Level), 0);

      // Quiet-gated config: apply exactly IDLE_CYCLES+2 after line release
      RxIn = 1'b0;
      tick(2);
      cfg_write(1'b1, 1'b1);
      check("qg_pending", 32'(CfgPending), 1);
      tick(30);
      check("qg_held_en", 32'(ParityEn), 0);
      check("qg_held_pend", 32'(CfgPending), 1);
      RxIn = 1'b1;
      tick(IDLE_CYCLES + 1);
      check("qg_early_en", 32'(ParityEn), 0);
      check("qg_early_pend", 32'(CfgPending), 1);
      tick();
      check("qg_en", 32'(ParityEn), 1);
      check("qg_type", 32'(ParityType), 1);
      check("qg_pend_low", 32'(CfgPending), 0);

      // Already-quiet line: n+1 pending, n+3 applied
      cfg_write(1'b0, 1'b0);
      check("fast_pend1", 32'(CfgPending), 1);
      check("fast_old1", 32'(ParityEn), 1);
      tick();
      check("fast_old2", 32'(ParityEn), 1);
      tick();
      check("fast_en", 32'(ParityEn), 0);
      check("fast_type", 32'(ParityType), 0);
      check("fast_pend3", 32'(CfgPending), 0);

      // Overwrite while pending: only the last request is applied
      RxIn = 1'b0;
      cfg_write(1'b1, 1'b0);
      cfg_write(1'b0, 1'b1);
      RxIn = 1'b1;
      for (int i = 0; i < IDLE_CYCLES + 4; i++) begin
         check("ovw_en_never", 32'(ParityEn), 0);
         tick();
      end
      check("ovw_type", 32'(ParityType), 1);
      check("ovw_pend", 32'(CfgPending), 0);

      // Mid-run asynchronous reset with bytes queued and a pending config
      cfg_write(1'b1, 1'b1);
      tick(2);
      check("pre_rst_en", 32'(ParityEn), 1);
      RxIn = 1'b0;
      cfg_write(1'b0, 1'b0);
      push_byte(8'h11);
      push_byte(8'h22);
      push_byte(8'h33);
      check("pre_rst_level", 32'(Level), 3);
      check("pre_rst_pend", 32'(CfgPending), 1);
      #2;
      RST = 1'b1;
      #1;
      check("arst_level", 32'(Level), 0);
      check("arst_valid", 32'(OutValid), 0);
      check("arst_overrun", 32'(Overrun), 0);
      check("arst_par_en", 32'(ParityEn), 0);
      check("arst_par_type", 32'(ParityType), 0);
      check("arst_pending", 32'(CfgPending), 0);
      check("arst_data", 32'(OutData), 0);
      tick();
      RST = 1'b0;
      RxIn = 1'b1;
      tick();
      check("post_rst_level", 32'(Level), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
